// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared FSM state type and AXI AR constants for the cache read arbiter
package cache_arb_pkg;
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   localparam logic [3:0] AR_LEN = 4'd3;
   localparam logic [2:0] AR_SIZE = 3'd2;
   localparam logic [1:0] AR_BURST_INCR = 2'b01;
   localparam logic [3:0] ID_IM = 4'd0;
   localparam logic [3:0] ID_DM = 4'd1;
   function automatic logic [31:0] line_align(input logic [31:0] a);
      return {a[31:4], 4'b0};
   endfunction
endpackage

// File: rtl/cache_arb_pick.sv
// cache_arb_pick: 2-way requester picker (round-robin with CACHE_ARB_RR_EN, else fixed DM-over-IM)
// Ports: clk/rst (async active-high), adv_i = a grant is being taken this cycle,
//        im_valid_i/dm_valid_i = requests, pick_dm_o = 1 selects DM, 0 selects IM.
module cache_arb_pick (
   input  logic clk,
   input  logic rst,
   input  logic adv_i,
   input  logic im_valid_i,
   input  logic dm_valid_i,
   output logic pick_dm_o
);
`ifdef CACHE_ARB_RR_EN
   // ptr_q = 1 gives DM priority; it moves to the side that just lost after every grant
   logic ptr_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr_q <= 1'b0;
      else if (adv_i) ptr_q <= ~pick_dm_o;
   assign pick_dm_o = dm_valid_i & (~im_valid_i | ptr_q);
`else
   logic unused_rr;
   assign unused_rr = ^{clk, rst, adv_i, im_valid_i};
   assign pick_dm_o = dm_valid_i;
`endif
endmodule

// File: rtl/cache_read_arbiter.sv
// cache_read_arbiter: arbitrates I/D-cache line misses onto one AXI read channel, one 4-beat burst at a time
// Ports: im_*/dm_* requester side (req handshake + returned beats), AR*/R* AXI master read channel,
//        burst_err pulses on a beat with a bad RLAST position or RID. Define CACHE_ARB_RR_EN for round-robin.
module cache_read_arbiter
   import cache_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        im_req_valid,
   input  logic [31:0] im_req_addr,
   output logic        im_req_ready,
   input  logic        dm_req_valid,
   input  logic [31:0] dm_req_addr,
   output logic        dm_req_ready,
   output logic        im_rvalid,
   output logic [31:0] im_rdata,
   output logic        im_rlast,
   output logic        dm_rvalid,
   output logic [31:0] dm_rdata,
   output logic        dm_rlast,
   output logic [3:0]  ARID,
   output logic [31:0] ARADDR,
   output logic [3:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [3:0]  RID,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY,
   output logic        burst_err
);
   state_t      state_q;
   logic        grant_q;
   logic [31:0] addr_q;
   logic [1:0]  cnt_q;
   logic        pick_dm;
   logic        any_req;
   logic        hs;
   logic        beat;
   logic        unused_rresp;
   assign any_req = im_req_valid | dm_req_valid;
   assign unused_rresp = ^RRESP;
   cache_arb_pick u_pick (
      .clk        (clk),
      .rst        (rst),
      .adv_i      (state_q == IDLE && any_req),
      .im_valid_i (im_req_valid),
      .dm_valid_i (dm_req_valid),
      .pick_dm_o  (pick_dm)
   );
   // grant_q and addr_q are only written in IDLE, so a requester dropping
   // valid early cannot disturb a burst already in flight
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (any_req) begin
               grant_q <= pick_dm;
               addr_q  <= line_align(pick_dm ? dm_req_addr : im_req_addr);
               state_q <= ADDR;
            end
            ADDR: if (ARREADY) begin
               cnt_q   <= '0;
               state_q <= DATA;
            end
            DATA: if (RVALID) begin
               cnt_q <= cnt_q + 2'd1;
               if (RLAST) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   assign ARVALID = state_q == ADDR;
   assign RREADY  = state_q == DATA;
   assign ARADDR  = addr_q;
   assign ARID    = grant_q ? ID_DM : ID_IM;
   assign ARLEN   = AR_LEN;
   assign ARSIZE  = AR_SIZE;
   assign ARBURST = AR_BURST_INCR;
   assign hs = ARVALID & ARREADY;
   assign im_req_ready = hs & ~grant_q;
   assign dm_req_ready = hs & grant_q;
   // beats pass straight through to the granted side in the same cycle
   assign beat = RREADY & RVALID;
   assign im_rvalid = beat & ~grant_q;
   assign dm_rvalid = beat & grant_q;
   assign im_rdata  = im_rvalid ? RDATA : '0;
   assign dm_rdata  = dm_rvalid ? RDATA : '0;
   assign im_rlast  = im_rvalid & RLAST;
   assign dm_rlast  = dm_rvalid & RLAST;
   assign burst_err = beat & ((RLAST != (cnt_q == 2'd3)) | (RID != ARID));
endmodule

// File: tb/tb_cache_read_arbiter.sv
// tb_cache_read_arbiter: directed stimulus with a queue-based scoreboard for cache_read_arbiter
module tb_cache_read_arbiter;
   logic        clk = 0, rst = 1;
   logic        im_req_valid = 0, dm_req_valid = 0;
   logic [31:0] im_req_addr = 0, dm_req_addr = 0;
   logic        im_req_ready, dm_req_ready;
   logic        im_rvalid, im_rlast, dm_rvalid, dm_rlast;
   logic [31:0] im_rdata, dm_rdata;
   logic [3:0]  ARID, ARLEN;
   logic [31:0] ARADDR;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID, ARREADY = 0;
   logic [3:0]  RID = 0;
   logic [31:0] RDATA = 0;
   logic [1:0]  RRESP = 0;
   logic        RLAST = 0, RVALID = 0;
   logic        RREADY, burst_err;
   int checks = 0, errors = 0;
   typedef struct {logic dm; logic [31:0] addr;} ar_t;
   typedef struct {logic dm; logic [31:0] data; logic last; logic err;} beat_t;
   ar_t   ar_q[$];
   beat_t bt_q[$];
   ar_t   ma;
   beat_t mb;

   cache_read_arbiter dut (
      .clk(clk), .rst(rst),
      .im_req_valid(im_req_valid), .im_req_addr(im_req_addr), .im_req_ready(im_req_ready),
      .dm_req_valid(dm_req_valid), .dm_req_addr(dm_req_addr), .dm_req_ready(dm_req_ready),
      .im_rvalid(im_rvalid), .im_rdata(im_rdata), .im_rlast(im_rlast),
      .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_rlast(dm_rlast),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .burst_err(burst_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ARVALID && ARREADY) begin
         if (ar_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ar: got ARADDR %h, required no AR handshake", ARADDR);
         end else begin
            ma = ar_q.pop_front();
            chk("ar_fields", {ARID, ARLEN, ARSIZE, ARBURST, ARADDR},
                {(ma.dm ? 4'd1 : 4'd0), 4'd3, 3'd2, 2'b01, ma.addr});
            chk("req_ready", {im_req_ready, dm_req_ready}, {!ma.dm, ma.dm});
         end
      end else if (im_req_ready || dm_req_ready) begin
         checks++; errors++;
         $display("FAIL unexpected_req_ready: got im=%b dm=%b, required 0 0", im_req_ready, dm_req_ready);
      end
      if (im_rvalid || dm_rvalid || burst_err) begin
         if (bt_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got im_rvalid=%b dm_rvalid=%b err=%b, required none",
                     im_rvalid, dm_rvalid, burst_err);
         end else begin
            mb = bt_q.pop_front();
            chk("beat", {im_rvalid, dm_rvalid, im_rlast, dm_rlast, burst_err, RREADY,
                         (mb.dm ? dm_rdata : im_rdata)},
                {!mb.dm, mb.dm, !mb.dm & mb.last, mb.dm & mb.last, mb.err, 1'b1, mb.data});
         end
      end
   end

   // serves one burst for requester dm; rst_at >= 0 asserts reset on that beat instead
   task automatic serve(input logic dm, input logic [31:0] addr, input int stall, input int nbeats,
                        input int last_at, input logic [3:0] rid, input logic [7:0] emask,
                        input logic [31:0] dbase, input int rst_at);
      int n = 0;
      while (!ARVALID && n < 20) begin @(posedge clk); #1; n++; end
      chk("arvalid_seen", ARVALID, 1);
      if (!ARVALID) return;
      for (int s = 0; s < stall; s++) begin
         chk("ar_stall", {ARVALID, im_req_ready, dm_req_ready, ARADDR}, {3'b100, addr});
         @(posedge clk); #1;
      end
      ar_q.push_back('{dm, addr});
      ARREADY = 1;
      @(posedge clk); #1;
      ARREADY = 0;
      if (dm) dm_req_valid = 0; else im_req_valid = 0;
      for (int i = 0; i < nbeats; i++) begin
         RVALID = 1; RDATA = dbase + i; RLAST = (i == last_at); RID = rid; RRESP = i[1:0];
         if (i == rst_at) begin
            rst = 1;
            #1;
            chk("rst_outputs", {ARVALID, RREADY, im_req_ready, dm_req_ready, im_rvalid, dm_rvalid,
                                im_rlast, dm_rlast, burst_err, ARADDR}, 0);
            @(posedge clk); #1;
            rst = 0;
            @(posedge clk); #1;
            chk("residual_beat", {RREADY, im_rvalid, dm_rvalid}, 0);
            RVALID = 0; RLAST = 0;
            return;
         end
         bt_q.push_back('{dm, dbase + i, i == last_at, emask[i]});
         @(posedge clk); #1;
      end
      RVALID = 0; RLAST = 0;
      chk("idle_after_burst", {ARVALID, RREADY}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run, required completion");
      $fatal(1);
   end

   initial begin
      im_req_valid = 1; im_req_addr = 32'h0000_0040;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {ARVALID, RREADY, im_req_ready, dm_req_ready, im_rvalid, dm_rvalid,
                            im_rlast, dm_rlast, burst_err}, 0);
      chk("reset_araddr", ARADDR, 0);
      im_req_valid = 0;
      rst = 0;
      @(posedge clk); #1;
      chk("idle_no_req", ARVALID, 0);
      im_req_valid = 1; im_req_addr = 32'h0000_2004;
      dm_req_valid = 1; dm_req_addr = 32'h0000_3018;
`ifdef CACHE_ARB_RR_EN
      serve(0, 32'h0000_2000, 0, 4, 3, 4'd0, 8'h00, 32'h1100_0000, -1);
      serve(1, 32'h0000_3010, 0, 4, 3, 4'd1, 8'h00, 32'h2200_0000, -1);
`else
      serve(1, 32'h0000_3010, 0, 4, 3, 4'd1, 8'h00, 32'h2200_0000, -1);
      serve(0, 32'h0000_2000, 0, 4, 3, 4'd0, 8'h00, 32'h1100_0000, -1);
`endif
      im_req_valid = 1; im_req_addr = 32'h0000_1234;
      serve(0, 32'h0000_1230, 0, 4, 3, 4'd0, 8'h00, 32'hA000_0000, -1);
      dm_req_valid = 1; dm_req_addr = 32'hDEAD_BEEF;
      serve(1, 32'hDEAD_BEE0, 5, 4, 3, 4'd1, 8'h00, 32'hB000_0010, -1);
      im_req_valid = 1; im_req_addr = 32'h0000_0104;
      serve(0, 32'h0000_0100, 0, 2, 1, 4'd0, 8'h02, 32'hC000_0000, -1);
      im_req_valid = 1; im_req_addr = 32'h0000_0208;
      serve(0, 32'h0000_0200, 0, 4, 3, 4'd1, 8'h0F, 32'hC100_0000, -1);
      dm_req_valid = 1; dm_req_addr = 32'h0000_030C;
      serve(1, 32'h0000_0300, 0, 5, 4, 4'd1, 8'h18, 32'hC200_0000, -1);
      im_req_valid = 1; im_req_addr = 32'h0000_8008;
      serve(0, 32'h0000_8000, 0, 4, 3, 4'd0, 8'h00, 32'hD000_0000, 1);
      dm_req_valid = 1; dm_req_addr = 32'h0000_5554;
      serve(1, 32'h0000_5550, 0, 4, 3, 4'd1, 8'h00, 32'hE000_0000, -1);
      repeat (2) @(posedge clk);
      #1;
      chk("queues_drained", ar_q.size() + bt_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
